// File: rtl/pilha_dados_ops.sv
// pilha_dados_ops -- single-clock Forth data stack for the asterixForth core.
//
// The top two cells (tos, nos) are held in registers so the ALU always sees
// them without a memory access. Cells three and deeper live in `mem`, where
// cell k (k >= 3, counted 1-based from the top) sits at mem[depth-k].
// One stack primitive executes per clock. A primitive that would underflow
// or overflow is refused: it leaves tos/nos/depth/mem untouched and raises
// the matching error flag instead.
//
// Optional feature macro: PILHA_ERR_STICKY_EN
//   defined   -> overflow/underflow hold until clear_err or reset
//   undefined -> overflow/underflow pulse for the one cycle after the failing
//                op, and clear_err has no effect
//
// Ports:
//   clock      single clock, rising edge
//   reset      asynchronous, active-high; clears tos/nos/depth/flags
//   op_valid   execute op this cycle
//   op         0 NOP, 1 PUSH, 2 DROP, 3 DUP, 4 SWAP, 5 OVER, 6 ROT, 7 REPLACE
//   data_in    operand for PUSH / REPLACE
//   clear_err  clears the sticky error flags
//   tos, nos   top and next-on-stack cells (registered)
//   depth      number of valid cells, 0 .. 2**DEPTH_LOG2
//   empty      depth == 0
//   full       depth == 2**DEPTH_LOG2
//   overflow   PUSH/DUP/OVER issued while full
//   underflow  op issued with too few cells on the stack

module pilha_dados_ops #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  op_valid,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  clear_err,
  output logic [DATA_WIDTH-1:0] tos,
  output logic [DATA_WIDTH-1:0] nos,
  output logic [DEPTH_LOG2:0]   depth,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int MEM_CELLS = (1 << DEPTH_LOG2) - 2;

  localparam logic [DEPTH_LOG2:0] FULL_DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] D1 = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0] D2 = (DEPTH_LOG2+1)'(2);
  localparam logic [DEPTH_LOG2:0] D3 = (DEPTH_LOG2+1)'(3);

  localparam logic [2:0] OP_PUSH    = 3'd1;
  localparam logic [2:0] OP_DROP    = 3'd2;
  localparam logic [2:0] OP_DUP     = 3'd3;
  localparam logic [2:0] OP_SWAP    = 3'd4;
  localparam logic [2:0] OP_OVER    = 3'd5;
  localparam logic [2:0] OP_ROT     = 3'd6;
  localparam logic [2:0] OP_REPLACE = 3'd7;

  logic [DATA_WIDTH-1:0] mem [MEM_CELLS];

  logic [DEPTH_LOG2-1:0] spill_addr;
  logic [DEPTH_LOG2-1:0] third_addr;
  logic [DATA_WIDTH-1:0] third;

  logic [DATA_WIDTH-1:0] tos_next;
  logic [DATA_WIDTH-1:0] nos_next;
  logic [DEPTH_LOG2:0]   depth_next;
  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] mem_waddr;
  logic                  ovf_now;
  logic                  unf_now;

  // spill_addr is where nos goes when the stack grows (mem[depth-2]);
  // third_addr is the current third cell (mem[depth-3]). Both wrap to
  // meaningless values on shallow stacks, so every use is gated on depth.
  assign spill_addr = DEPTH_LOG2'(depth - D2);
  assign third_addr = DEPTH_LOG2'(depth - D3);

  // A stack without a third cell reads as zero, so a DROP at depth <= 2
  // loads 0 into the vacated nos register.
  assign third = (depth >= D3) ? mem[third_addr] : '0;

  assign empty = (depth == '0);
  assign full  = (depth == FULL_DEPTH);

  // Next-state decode: guards are evaluated against the current depth first;
  // a refused op only raises its error and leaves every other default alone.
  always_comb begin
    tos_next   = tos;
    nos_next   = nos;
    depth_next = depth;
    mem_we     = 1'b0;
    mem_waddr  = spill_addr;
    ovf_now    = 1'b0;
    unf_now    = 1'b0;
    if (op_valid) begin
      case (op)
        OP_PUSH: begin
          if (full) begin
            ovf_now = 1'b1;
          end else begin
            tos_next   = data_in;
            nos_next   = tos;
            depth_next = depth + D1;
            mem_we     = (depth >= D2);
          end
        end
        OP_DROP: begin
          if (empty) begin
            unf_now = 1'b1;
          end else begin
            tos_next   = nos;
            nos_next   = third;
            depth_next = depth - D1;
          end
        end
        OP_DUP: begin
          if (empty) begin
            unf_now = 1'b1;
          end else if (full) begin
            ovf_now = 1'b1;
          end else begin
            nos_next   = tos;
            depth_next = depth + D1;
            mem_we     = (depth >= D2);
          end
        end
        OP_SWAP: begin
          if (depth < D2) begin
            unf_now = 1'b1;
          end else begin
            tos_next = nos;
            nos_next = tos;
          end
        end
        OP_OVER: begin
          if (depth < D2) begin
            unf_now = 1'b1;
          end else if (full) begin
            ovf_now = 1'b1;
          end else begin
            tos_next   = nos;
            nos_next   = tos;
            depth_next = depth + D1;
            mem_we     = 1'b1;
          end
        end
        OP_ROT: begin
          // a b c -> b c a : old nos drops into the third slot, old third
          // rises to tos.
          if (depth < D3) begin
            unf_now = 1'b1;
          end else begin
            tos_next  = third;
            nos_next  = tos;
            mem_we    = 1'b1;
            mem_waddr = third_addr;
          end
        end
        OP_REPLACE: begin
          if (empty) begin
            unf_now = 1'b1;
          end else begin
            tos_next = data_in;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Deep storage is not reset: after reset depth is zero, so no stale cell
  // can be read before it has been written again. Every write stores the
  // pre-op nos.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_waddr] <= nos;
    end
  end

  // Architectural registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tos   <= '0;
      nos   <= '0;
      depth <= '0;
    end else begin
      tos   <= tos_next;
      nos   <= nos_next;
      depth <= depth_next;
    end
  end

`ifdef PILHA_ERR_STICKY_EN
  // Sticky flags: a new error in the same cycle as clear_err wins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ovf_now | (overflow  & ~clear_err);
      underflow <= unf_now | (underflow & ~clear_err);
    end
  end
`else
  // Pulse flags: high only for the cycle after the refused op.
  logic unused_clear_err;
  assign unused_clear_err = clear_err;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ovf_now;
      underflow <= unf_now;
    end
  end
`endif

endmodule

// File: tb/tb_pilha_dados_ops.sv
// tb_pilha_dados_ops -- scoreboard bench for pilha_dados_ops.
//
// The driver applies one op per cycle and, after the sampling edge, advances
// a queue-based model of the stack and pushes the expected visible state into
// a scoreboard queue. A separate monitor pops one entry at every falling edge
// and compares it against the DUT outputs.

module tb_pilha_dados_ops;

  localparam int DW  = 16;
  localparam int DL2 = 3;
  localparam int CAP = 1 << DL2;

  localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, DROP = 3'd2, DUP = 3'd3,
                         SWAP = 3'd4, OVER = 3'd5, ROT = 3'd6, REPLACE = 3'd7;

  logic          clock = 1'b0;
  logic          reset;
  logic          op_valid;
  logic [2:0]    op;
  logic [DW-1:0] data_in;
  logic          clear_err;
  logic [DW-1:0] tos;
  logic [DW-1:0] nos;
  logic [DL2:0]  depth;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          underflow;

  typedef struct {
    logic [DW-1:0] tos;
    logic [DW-1:0] nos;
    int            depth;
    bit            ovf;
    bit            unf;
  } exp_t;

  exp_t          expected_q[$];
  logic [DW-1:0] ref_stack[$];
  bit            ref_ovf;
  bit            ref_unf;

  int total = 0;
  int bad   = 0;

  pilha_dados_ops #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL2)) dut (
    .clock     (clock),
    .reset     (reset),
    .op_valid  (op_valid),
    .op        (op),
    .data_in   (data_in),
    .clear_err (clear_err),
    .tos       (tos),
    .nos       (nos),
    .depth     (depth),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clock = ~clock;

  // Visible state as the stack rules define it: cells beyond depth read 0.
  function automatic exp_t snapshot();
    exp_t e;
    int n = ref_stack.size();
    e.tos   = (n >= 1) ? ref_stack[n-1] : '0;
    e.nos   = (n >= 2) ? ref_stack[n-2] : '0;
    e.depth = n;
    e.ovf   = ref_ovf;
    e.unf   = ref_unf;
    return e;
  endfunction

  // Reference model: the stack is a queue whose last element is the top.
  task automatic modelStep(input logic v, input logic [2:0] o,
                           input logic [DW-1:0] d, input logic c);
    bit e_o = 1'b0;
    bit e_u = 1'b0;
    int n = ref_stack.size();
    logic [DW-1:0] t;
    if (v) begin
      case (o)
        PUSH:    if (n == CAP) e_o = 1'b1; else ref_stack.push_back(d);
        DROP:    if (n < 1) e_u = 1'b1; else void'(ref_stack.pop_back());
        DUP:     if (n < 1) e_u = 1'b1; else if (n == CAP) e_o = 1'b1;
                 else ref_stack.push_back(ref_stack[n-1]);
        SWAP:    if (n < 2) e_u = 1'b1;
                 else begin
                   t = ref_stack[n-1];
                   ref_stack[n-1] = ref_stack[n-2];
                   ref_stack[n-2] = t;
                 end
        OVER:    if (n < 2) e_u = 1'b1; else if (n == CAP) e_o = 1'b1;
                 else ref_stack.push_back(ref_stack[n-2]);
        ROT:     if (n < 3) e_u = 1'b1;
                 else begin
                   t = ref_stack[n-3];
                   ref_stack.delete(n-3);
                   ref_stack.push_back(t);
                 end
        REPLACE: if (n < 1) e_u = 1'b1; else ref_stack[n-1] = d;
        default: ;
      endcase
    end
`ifdef PILHA_ERR_STICKY_EN
    ref_ovf = e_o | (ref_ovf & ~c);
    ref_unf = e_u | (ref_unf & ~c);
`else
    ref_ovf = e_o;
    ref_unf = e_u;
    if (c) begin
    end
`endif
  endtask

  task automatic checkField(input string name, input int actual, input int required);
    total++;
    if (actual != required) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h want 0x%0h at %0t", name, actual, required, $time);
    end
  endtask

  task automatic checkOutput(input exp_t e, input string tag);
    checkField({tag, ".tos"},       int'(tos),       int'(e.tos));
    checkField({tag, ".nos"},       int'(nos),       int'(e.nos));
    checkField({tag, ".depth"},     int'(depth),     e.depth);
    checkField({tag, ".empty"},     int'(empty),     int'(e.depth == 0));
    checkField({tag, ".full"},      int'(full),      int'(e.depth == CAP));
    checkField({tag, ".overflow"},  int'(overflow),  int'(e.ovf));
    checkField({tag, ".underflow"}, int'(underflow), int'(e.unf));
  endtask

  // Drive one cycle of inputs, then record what the DUT must show after the
  // sampling edge.
  task automatic applyStimulus(input logic v, input logic [2:0] o,
                               input logic [DW-1:0] d, input logic c);
    op_valid  = v;
    op        = o;
    data_in   = d;
    clear_err = c;
    @(posedge clock);
    modelStep(v, o, d, c);
    expected_q.push_back(snapshot());
    #1;
  endtask

  // Monitor: outputs are stable mid-cycle, so compare at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (expected_q.size() > 0) begin
        e = expected_q.pop_front();
        checkOutput(e, "sb");
      end
    end
  end

  initial begin
    exp_t z;
    reset     = 1'b1;
    op_valid  = 1'b0;
    op        = NOP;
    data_in   = '0;
    clear_err = 1'b0;
    ref_ovf   = 1'b0;
    ref_unf   = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    expected_q.push_back(snapshot());

    $display("[TB] push / rot / swap / drop");
    applyStimulus(1, PUSH, 16'h0011, 0);
    applyStimulus(1, PUSH, 16'h0022, 0);
    applyStimulus(1, PUSH, 16'h0033, 0);
    applyStimulus(1, ROT,  16'h0000, 0);
    applyStimulus(1, SWAP, 16'h0000, 0);
    repeat (3) applyStimulus(1, DROP, 16'h0000, 0);

    $display("[TB] underflow on empty, flag behaviour");
    applyStimulus(1, DROP, 16'h0000, 0);
    repeat (5) applyStimulus(1, NOP, 16'h0000, 0);
    applyStimulus(0, NOP, 16'h0000, 1);
    applyStimulus(0, NOP, 16'h0000, 0);
    applyStimulus(1, DROP, 16'h0000, 1);
    applyStimulus(0, NOP, 16'h0000, 0);

    $display("[TB] depth-1 guards, dup, replace");
    applyStimulus(1, PUSH,    16'h00AA, 0);
    applyStimulus(1, OVER,    16'h0000, 0);
    applyStimulus(1, ROT,     16'h0000, 0);
    applyStimulus(1, DUP,     16'h0000, 0);
    applyStimulus(1, REPLACE, 16'h5555, 0);
    repeat (2) applyStimulus(1, DROP, 16'h0000, 0);
    applyStimulus(1, REPLACE, 16'h1234, 1);

    $display("[TB] fill to capacity and overflow");
    for (int i = 1; i <= CAP; i++) applyStimulus(1, PUSH, DW'(i), 0);
    applyStimulus(1, DUP,  16'h0000, 0);
    applyStimulus(1, PUSH, 16'hBEEF, 0);
    applyStimulus(1, OVER, 16'h0000, 1);
    applyStimulus(1, ROT,  16'h0000, 0);
    for (int i = 0; i <= CAP; i++) applyStimulus(1, DROP, 16'h0000, 0);

    $display("[TB] random ops");
    for (int i = 0; i < 300; i++)
      applyStimulus(logic'($urandom_range(0, 9) != 0), 3'($urandom_range(0, 7)),
                    DW'($urandom), logic'($urandom_range(0, 9) == 0));
    for (int i = 0; i < 200; i++)
      applyStimulus(1'b1, ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : DROP,
                    DW'($urandom), logic'($urandom_range(0, 9) == 0));

    $display("[TB] async reset mid-stream");
    while (ref_stack.size() > 0) applyStimulus(1, DROP, 16'h0000, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1, PUSH, DW'($urandom), 0);
    #5;
    reset = 1'b1;
    ref_stack.delete();
    ref_ovf = 1'b0;
    ref_unf = 1'b0;
    z = snapshot();
    #1 checkOutput(z, "async_reset");
    @(posedge clock);
    #1 reset = 1'b0;
    applyStimulus(1, PUSH, 16'h0007, 0);
    applyStimulus(0, NOP,  16'h0000, 0);

    repeat (2) @(negedge clock);
    #1;
    checkField("scoreboard_drained", expected_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
